bcd_updn_counter: RTL and testbench
===================================

BCD_UPDN_COUNTER -- requirements
Module: bcd_updn_counter

Interface
REQ-001 Parameter DIGITS, default 2, sets the number of BCD decades (legal 1..8).
REQ-002 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-003 Port clk  in  1  is the clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  is the reset: synchronous, active-high.
REQ-005 Port en  in  1  is the count enable; one step per clk edge while high.
REQ-006 Port up  in  1  is the direction: 1 = increment, 0 = decrement.
REQ-007 Port load  in  1  is the parallel-load request.
REQ-008 Port load_val  in  4*DIGITS  is the load value: packed BCD, digit 0 in [3:0].
REQ-009 Port q  out  4*DIGITS  is the registered packed BCD count, digit 0 in [3:0].
REQ-010 Port tc  out  1  is the combinational terminal count: en & (up ? q==all-9 : q==all-0).
REQ-011 Port wrap  out  1  is a registered one-cycle pulse, high in the cycle q shows a wrapped value.
REQ-012 Port sat  out  1  is a registered level, high while a saturated count is being held.
REQ-013 Port load_err  out  1  is a registered one-cycle pulse flagging a rejected load.

Function
REQ-014 Per edge, priority SHALL be rst > load > en > hold.
REQ-015 On load, when every load_val digit is <= 9, q SHALL take load_val at that edge, and wrap and sat SHALL clear.
REQ-016 On load, when any load_val digit is > 9, q SHALL hold, and load_err SHALL be 1 for exactly the next cycle.
REQ-017 load SHALL take effect regardless of en or up.
REQ-018 For an up count, digit 0 SHALL increment; each digit at 9 with carry-in SHALL go to 0 and carry out; all carries SHALL resolve in the same edge (zero latency).
REQ-019 For a down count, digit 0 SHALL decrement; each digit at 0 with borrow-in SHALL go to 9 and borrow out; all borrows SHALL resolve in the same edge.
REQ-020 With SATURATE=0: up from all-9 SHALL give all-0, down from all-0 SHALL give all-9, and wrap SHALL pulse for 1 cycle.
REQ-021 With SATURATE=1: up at all-9 or down at all-0 SHALL hold q with wrap=0, and set sat; sat SHALL clear on the first edge where q changes.
REQ-022 Back-to-back wraps (DIGITS=1, continuous en) SHALL assert wrap on every wrapping edge.
REQ-023 A direction change SHALL take effect on the same edge that up is sampled, with no dead cycle.
REQ-024 Every digit of q SHALL be <= 9 at all times after reset.
REQ-025 en=0 with load=0 SHALL hold q, and wrap and load_err SHALL be 0 on the following cycle.

Reset
REQ-026 rst SHALL set q to all-0, and wrap, sat and load_err to 0, on the next clk edge.
REQ-027 rst SHALL override a simultaneous load or en.
REQ-028 rst asserted mid-count SHALL discard any pending carry or borrow.
REQ-029 No output SHALL depend asynchronously on rst.

Structure
REQ-030 Shared package bcd_pkg SHALL hold BCD_MAX (4'd9), BCD_MIN (4'd0) and a digit-validity function; this block SHALL import it.
REQ-031 One sub-module, bcd_digit, SHALL be instantiated DIGITS times via generate; it is combinational, with these signals:
- inputs digit, up, cin;
- outputs next_digit, cout.
REQ-032 The top level SHALL own all registers, the carry chain gating, load validation and the flag logic.

Verification
REQ-033 DIGITS=2, SATURATE=0, load 8'h98, up=1, en=1 for 3 edges -> q = 99, 00, 01; wrap high only in the cycle q=00; tc=1 while q=99.
REQ-034 DIGITS=2, load 8'h01, up=0, en=1 for 3 edges -> q = 00, 99, 98; wrap pulses when q=99.
REQ-035 DIGITS=2, SATURATE=1, load 8'h99, up=1, en=1 for 4 edges -> q stays 99, sat=1, wrap=0; then up=0 -> q=98 and sat=0.
REQ-036 DIGITS=3, load 12'h1A5 -> q unchanged, load_err=1 for 1 cycle; then load 12'h109 -> q=109.
REQ-037 DIGITS=2, at q=45 assert rst, load and en together -> q=00 and all flags 0.
REQ-038 DIGITS=4, random en/up/load for 10k cycles against a decimal reference model -> q always matches and every digit is <= 9.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions.
// Contents:
//   BCD_MAX / BCD_MIN : the largest and smallest legal decimal digit values.
//   bcd_digit_valid   : returns 1 when a 4-bit nibble holds a legal decimal digit.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the counter chain. This block is purely combinational.
// Ports:
//   digit      in  4 : current digit value
//   up         in  1 : 1 = increment, 0 = decrement
//   cin        in  1 : carry (up) or borrow (down) arriving from the lower decade
//   next_digit out 4 : digit value after this step
//   cout       out 1 : carry or borrow passed to the next decade
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] next_digit,
  output logic       cout
);

  // Step the digit by one when a carry or borrow arrives; otherwise pass it through.
  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up) begin
        // The >= comparison also steers an illegal nibble back to 0.
        if (digit >= BCD_MAX) begin
          next_digit = BCD_MIN;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
          cout       = 1'b0;
        end
      end else begin
        if (digit == BCD_MIN) begin
          next_digit = BCD_MAX;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
          cout       = 1'b0;
        end
      end
    end else begin
      next_digit = digit;
      cout       = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_updn_counter.sv
// Multi-decade BCD up/down counter with parallel load, wrap and saturate modes.
// Parameters:
//   DIGITS   : number of BCD decades (1..8)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
// Ports:
//   clk      in  1        : clock; all state changes on its rising edge
//   rst      in  1        : synchronous active-high reset
//   en       in  1        : count enable
//   up       in  1        : direction, 1 = increment
//   load     in  1        : parallel-load request
//   load_val in  4*DIGITS : packed BCD load value, digit 0 in [3:0]
//   q        out 4*DIGITS : registered packed BCD count
//   tc       out 1        : combinational terminal count
//   wrap     out 1        : one-cycle pulse in the cycle q shows a wrapped value
//   sat      out 1        : level, high while a saturated count is being held
//   load_err out 1        : one-cycle pulse after a rejected load
module bcd_updn_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                wrap,
  output logic                sat,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q_r;
  logic            wrap_r;
  logic            sat_r;
  logic            load_err_r;

  logic [DIGITS:0] carry_s;
  logic [W-1:0]    next_s;
  logic            limit_s;
  logic            load_ok_s;
  logic            all9_s;
  logic            all0_s;

  // The chain only starts rippling when counting is enabled.
  assign carry_s[0] = en;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gen_digit
      bcd_digit u_digit (
        .digit      (q_r[4*g +: 4]),
        .up         (up),
        .cin        (carry_s[g]),
        .next_digit (next_s[4*g +: 4]),
        .cout       (carry_s[g+1])
      );
    end
  endgenerate

  // A carry out of the top decade means this step crosses a limit.
  assign limit_s = carry_s[DIGITS];

  assign all9_s = (q_r == {DIGITS{BCD_MAX}});
  assign all0_s = (q_r == {DIGITS{BCD_MIN}});

  // Load is accepted only when every nibble is a legal decimal digit.
  always_comb begin
    load_ok_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(load_val[4*i +: 4])) begin
        load_ok_s = 1'b0;
      end else begin
        load_ok_s = load_ok_s;
      end
    end
  end

  // Count register and flags: reset, then load, then count, then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r        <= {W{1'b0}};
      wrap_r     <= 1'b0;
      sat_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else if (load) begin
      wrap_r <= 1'b0;
      if (load_ok_s) begin
        q_r        <= load_val;
        sat_r      <= 1'b0;
        load_err_r <= 1'b0;
      end else begin
        // Rejected load: count and saturation state are left as they were.
        load_err_r <= 1'b1;
      end
    end else if (en) begin
      load_err_r <= 1'b0;
      if (limit_s && SATURATE) begin
        wrap_r <= 1'b0;
        sat_r  <= 1'b1;
      end else begin
        q_r    <= next_s;
        wrap_r <= limit_s;
        sat_r  <= 1'b0;
      end
    end else begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  assign q        = q_r;
  assign wrap     = wrap_r;
  assign sat      = sat_r;
  assign load_err = load_err_r;
  assign tc       = en & (up ? all9_s : all0_s);

endmodule

// File: tb/tb_bcd_updn_counter.sv
// Self-checking bench for bcd_updn_counter. Five instances with different
// DIGITS/SATURATE settings share the control inputs; each is compared every
// cycle against an integer-valued decimal model, plus directed scenario checks.
module tb_bcd_updn_counter;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst, en, up, load;
  logic [31:0] lvk [N];

  wire [7:0]  q0, q1;
  wire [11:0] q2;
  wire [15:0] q3;
  wire [3:0]  q4;
  wire [N-1:0] tc_o, wr_o, sat_o, le_o;
  wire [31:0] qo [N];

  assign qo[0] = {24'd0, q0};
  assign qo[1] = {24'd0, q1};
  assign qo[2] = {20'd0, q2};
  assign qo[3] = {16'd0, q3};
  assign qo[4] = {28'd0, q4};

  always #5 clk = ~clk;

  bcd_updn_counter #(.DIGITS(2), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lvk[0][7:0]),
    .q(q0), .tc(tc_o[0]), .wrap(wr_o[0]), .sat(sat_o[0]), .load_err(le_o[0]));
  bcd_updn_counter #(.DIGITS(2), .SATURATE(1'b1)) u_s2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lvk[1][7:0]),
    .q(q1), .tc(tc_o[1]), .wrap(wr_o[1]), .sat(sat_o[1]), .load_err(le_o[1]));
  bcd_updn_counter #(.DIGITS(3), .SATURATE(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lvk[2][11:0]),
    .q(q2), .tc(tc_o[2]), .wrap(wr_o[2]), .sat(sat_o[2]), .load_err(le_o[2]));
  bcd_updn_counter #(.DIGITS(4), .SATURATE(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lvk[3][15:0]),
    .q(q3), .tc(tc_o[3]), .wrap(wr_o[3]), .sat(sat_o[3]), .load_err(le_o[3]));
  bcd_updn_counter #(.DIGITS(1), .SATURATE(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lvk[4][3:0]),
    .q(q4), .tc(tc_o[4]), .wrap(wr_o[4]), .sat(sat_o[4]), .load_err(le_o[4]));

  int total = 0;
  int bad   = 0;

  int dig_n    [N] = '{2, 2, 3, 4, 1};
  bit sat_mode [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Reference model state: the count as a plain integer.
  int mval  [N];
  bit mwrap [N];
  bit msat  [N];
  bit mlerr [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit lv_valid(input logic [31:0] v, input int d);
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [31:0] v, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v, input int d);
    logic [31:0] r = 32'd0;
    int t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int k, input bit r, input bit l, input bit e, input bit u);
    int maxv = pow10(dig_n[k]) - 1;
    if (r) begin
      mval[k] = 0; mwrap[k] = 1'b0; msat[k] = 1'b0; mlerr[k] = 1'b0;
    end else if (l) begin
      mwrap[k] = 1'b0;
      if (lv_valid(lvk[k], dig_n[k])) begin
        mval[k] = bcd2int(lvk[k], dig_n[k]); msat[k] = 1'b0; mlerr[k] = 1'b0;
      end else begin
        mlerr[k] = 1'b1;
      end
    end else if (e) begin
      mlerr[k] = 1'b0;
      if ((u && mval[k] == maxv) || (!u && mval[k] == 0)) begin
        if (sat_mode[k]) begin
          mwrap[k] = 1'b0; msat[k] = 1'b1;
        end else begin
          mval[k] = u ? 0 : maxv; mwrap[k] = 1'b1; msat[k] = 1'b0;
        end
      end else begin
        mval[k] = u ? mval[k] + 1 : mval[k] - 1;
        mwrap[k] = 1'b0; msat[k] = 1'b0;
      end
    end else begin
      mwrap[k] = 1'b0; mlerr[k] = 1'b0;
    end
  endtask

  // One clock cycle: drive, check tc, advance model, check registered outputs.
  task automatic step(input bit r, input bit l, input bit e, input bit u);
    rst = r; load = l; en = e; up = u;
    #1;
    for (int k = 0; k < N; k++) begin
      int maxv = pow10(dig_n[k]) - 1;
      bit etc = e && (u ? (mval[k] == maxv) : (mval[k] == 0));
      chk($sformatf("tc%0d", k), {31'd0, tc_o[k]}, {31'd0, etc});
      model_step(k, r, l, e, u);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("q%0d", k), qo[k], int2bcd(mval[k], dig_n[k]));
      chk($sformatf("wrap%0d", k), {31'd0, wr_o[k]}, {31'd0, mwrap[k]});
      chk($sformatf("sat%0d", k), {31'd0, sat_o[k]}, {31'd0, msat[k]});
      chk($sformatf("lerr%0d", k), {31'd0, le_o[k]}, {31'd0, mlerr[k]});
    end
  endtask

  task automatic set_lv(input logic [31:0] v);
    for (int k = 0; k < N; k++) lvk[k] = v;
  endtask

  function automatic logic [31:0] rand_lv(input int d);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
    if ($urandom_range(3, 0) == 0) r[4*$urandom_range(d - 1, 0) +: 4] = 4'($urandom_range(15, 10));
    return r;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0;
    set_lv(32'd0);
    for (int k = 0; k < N; k++) begin
      mval[k] = 0; mwrap[k] = 1'b0; msat[k] = 1'b0; mlerr[k] = 1'b0;
    end

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_q", qo[3], 32'h0);

    // Up through 99 with wrap.
    set_lv(32'h98);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t33_load", qo[0], 32'h98);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t33_q99", qo[0], 32'h99);
    chk("t33_tc", {31'd0, tc_o[0]}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t33_q00", qo[0], 32'h00);
    chk("t33_wrap", {31'd0, wr_o[0]}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t33_q01", qo[0], 32'h01);
    chk("t33_nowrap", {31'd0, wr_o[0]}, 32'd0);

    // Down through 00 with wrap.
    set_lv(32'h01);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t34_q00", qo[0], 32'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t34_q99", qo[0], 32'h99);
    chk("t34_wrap", {31'd0, wr_o[0]}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t34_q98", qo[0], 32'h98);

    // Saturation hold and release.
    set_lv(32'h99);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t35_q", qo[1], 32'h99);
    chk("t35_sat", {31'd0, sat_o[1]}, 32'd1);
    chk("t35_wrap", {31'd0, wr_o[1]}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t35_q98", qo[1], 32'h98);
    chk("t35_unsat", {31'd0, sat_o[1]}, 32'd0);

    // Rejected then accepted load on the 3-digit counter.
    set_lv(32'h321);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lvk[2] = 32'h1A5;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t36_hold", qo[2], 32'h321);
    chk("t36_lerr", {31'd0, le_o[2]}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t36_lerr_clr", {31'd0, le_o[2]}, 32'd0);
    lvk[2] = 32'h109;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t36_q109", qo[2], 32'h109);

    // Reset beats load and enable.
    set_lv(32'h45);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t37_q", qo[0], 32'h00);

    // Back-to-back wraps on one digit, reversing direction each edge.
    set_lv(32'h9);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t22_w1", {31'd0, wr_o[4]}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t22_q9", qo[4], 32'h9);
    chk("t22_w2", {31'd0, wr_o[4]}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t22_w3", {31'd0, wr_o[4]}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t25_wrap0", {31'd0, wr_o[4]}, 32'd0);

    // Randomized run.
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) lvk[k] = rand_lv(dig_n[k]);
      step($urandom_range(199, 0) == 0, $urandom_range(9, 0) == 0,
           $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1);
      for (int i = 0; i < 4; i++) chk("digit_range", {31'd0, qo[3][4*i +: 4] <= 4'd9}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
